// File: rtl/gray_counter.sv
// gray_counter
//   Up/down counter that registers both the binary count and its
//   reflected-binary Gray code, so either form is glitch-free every cycle.
//   Supports synchronous load of a binary or Gray start value and a choice
//   of wrap-around or saturation at the count limits.
//
// Parameters
//   len   counter width in bits (>= 2)
//   WRAP  1: wrap modulo 2^len, 0: saturate at 0 and 2^len-1
//
// Ports
//   CLK        in   rising-edge clock
//   RST_N      in   synchronous active-low reset
//   EN         in   count enable, one step per cycle
//   UP         in   1 = increment, 0 = decrement
//   LOAD       in   synchronous load strobe (beats EN)
//   LOAD_GRAY  in   1 = LOAD_VAL is Gray coded, 0 = binary
//   LOAD_VAL   in   value to load [len]
//   BIN        out  registered binary count [len]
//   GRAY       out  registered Gray code of BIN [len]
//   TC         out  registered terminal-count pulse
module gray_counter #(
  parameter int len  = 4,
  parameter bit WRAP = 1'b1
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           EN,
  input  logic           UP,
  input  logic           LOAD,
  input  logic           LOAD_GRAY,
  input  logic [len-1:0] LOAD_VAL,
  output logic [len-1:0] BIN,
  output logic [len-1:0] GRAY,
  output logic           TC
);

  localparam logic [len-1:0] ONE = len'(1);
  localparam logic [len-1:0] MAX = {len{1'b1}};

  function automatic logic [len-1:0] f_gray(input logic [len-1:0] x);
    return x ^ (x >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [len-1:0] f_gray2bin(input logic [len-1:0] g);
    logic [len-1:0] b;
    b = '0;
    b[len-1] = g[len-1];
    for (int i = len - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [len-1:0] r_bin;
  logic [len-1:0] r_gray;
  logic           r_tc;

  logic [len-1:0] w_bin_nxt;
  logic           w_tc_nxt;
  logic           w_at_max;
  logic           w_at_min;

  assign w_at_max = (r_bin == MAX);
  assign w_at_min = (r_bin == '0);

  always_comb begin
    w_bin_nxt = r_bin;
    w_tc_nxt  = 1'b0;
    if (LOAD) begin
      w_bin_nxt = LOAD_GRAY ? f_gray2bin(LOAD_VAL) : LOAD_VAL;
    end else if (EN) begin
      if (UP) begin
        if (w_at_max) begin
          w_tc_nxt  = 1'b1;
          w_bin_nxt = WRAP ? '0 : MAX;
        end else begin
          w_bin_nxt = r_bin + ONE;
        end
      end else begin
        if (w_at_min) begin
          w_tc_nxt  = 1'b1;
          w_bin_nxt = WRAP ? MAX : '0;
        end else begin
          w_bin_nxt = r_bin - ONE;
        end
      end
    end
  end

  // Register stage: Gray is derived from the next binary value so both
  // outputs update on the same edge and stay consistent.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_tc   <= 1'b0;
    end else begin
      r_bin  <= w_bin_nxt;
      r_gray <= f_gray(w_bin_nxt);
      r_tc   <= w_tc_nxt;
    end
  end

  assign BIN  = r_bin;
  assign GRAY = r_gray;
  assign TC   = r_tc;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: three instances (len=4 wrap, len=4 saturate,
// len=8 wrap) share one set of control inputs. An arithmetic reference
// model tracks each instance and is compared on every falling edge;
// directed literal checks pin the model to hand-derived values.
module tb_gray_counter;

  logic       clk;
  logic       rst_n, en, up, load, load_gray;
  logic [7:0] load_val;

  logic [3:0] bin_a, gray_a, bin_b, gray_b;
  logic [7:0] bin_c, gray_c;
  logic       tc_a, tc_b, tc_c;

  int nchk = 0;
  int nerr = 0;

  int mb_a, mb_b, mb_c;
  bit mt_a, mt_b, mt_c;
  bit armed = 1'b0;

  logic [3:0] gtab [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                            4'b0111, 4'b0101, 4'b0100, 4'b1100,
                            4'b1101, 4'b1111, 4'b1110, 4'b1010,
                            4'b1011, 4'b1001, 4'b1000, 4'b0000};

  gray_counter #(.len(4), .WRAP(1'b1)) u_a (
    .CLK(clk), .RST_N(rst_n), .EN(en), .UP(up), .LOAD(load),
    .LOAD_GRAY(load_gray), .LOAD_VAL(load_val[3:0]),
    .BIN(bin_a), .GRAY(gray_a), .TC(tc_a));

  gray_counter #(.len(4), .WRAP(1'b0)) u_b (
    .CLK(clk), .RST_N(rst_n), .EN(en), .UP(up), .LOAD(load),
    .LOAD_GRAY(load_gray), .LOAD_VAL(load_val[3:0]),
    .BIN(bin_b), .GRAY(gray_b), .TC(tc_b));

  gray_counter #(.len(8), .WRAP(1'b1)) u_c (
    .CLK(clk), .RST_N(rst_n), .EN(en), .UP(up), .LOAD(load),
    .LOAD_GRAY(load_gray), .LOAD_VAL(load_val),
    .BIN(bin_c), .GRAY(gray_c), .TC(tc_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int gray_of(input int x);
    return x ^ (x >> 1);
  endfunction

  // Prefix XOR of all right shifts recovers the binary value.
  function automatic int ungray(input int g);
    int r = 0;
    for (int s = g; s != 0; s = s >> 1) r = r ^ s;
    return r;
  endfunction

  function automatic int nxt_b(input int L, input bit W, input int b,
                               input bit rn, input bit e, input bit u,
                               input bit ld, input bit lg, input int lv);
    int mx = (1 << L) - 1;
    int v  = lv & mx;
    if (!rn) return 0;
    if (ld) return lg ? ungray(v) : v;
    if (e && u) return (b == mx) ? (W ? 0 : mx) : b + 1;
    if (e && !u) return (b == 0) ? (W ? mx : 0) : b - 1;
    return b;
  endfunction

  function automatic bit nxt_tc(input int L, input int b, input bit rn,
                                input bit e, input bit u, input bit ld);
    int mx = (1 << L) - 1;
    if (!rn || ld) return 1'b0;
    if (e && u) return b == mx;
    if (e && !u) return b == 0;
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    mb_a <= nxt_b(4, 1'b1, mb_a, rst_n, en, up, load, load_gray, int'(load_val));
    mb_b <= nxt_b(4, 1'b0, mb_b, rst_n, en, up, load, load_gray, int'(load_val));
    mb_c <= nxt_b(8, 1'b1, mb_c, rst_n, en, up, load, load_gray, int'(load_val));
    mt_a <= nxt_tc(4, mb_a, rst_n, en, up, load);
    mt_b <= nxt_tc(4, mb_b, rst_n, en, up, load);
    mt_c <= nxt_tc(8, mb_c, rst_n, en, up, load);
    if (!rst_n) armed <= 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("model_bin_a",  32'(bin_a),  32'(mb_a));
      chk("model_gray_a", 32'(gray_a), 32'(gray_of(mb_a)));
      chk("model_tc_a",   32'(tc_a),   32'(mt_a));
      chk("model_bin_b",  32'(bin_b),  32'(mb_b));
      chk("model_gray_b", 32'(gray_b), 32'(gray_of(mb_b)));
      chk("model_tc_b",   32'(tc_b),   32'(mt_b));
      chk("model_bin_c",  32'(bin_c),  32'(mb_c));
      chk("model_gray_c", 32'(gray_c), 32'(gray_of(mb_c)));
      chk("model_tc_c",   32'(tc_c),   32'(mt_c));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_gray = 1'b0;
    load_val = 8'h00;

    // reset overrides enable, and in the second cycle a load as well
    step();
    chk("rst_bin", 32'(bin_a), 0);
    chk("rst_gray", 32'(gray_a), 0);
    chk("rst_tc", 32'(tc_a), 0);
    load = 1'b1; load_val = 8'hA5;
    step();
    chk("rst_ld_bin_a", 32'(bin_a), 0);
    chk("rst_ld_bin_c", 32'(bin_c), 0);
    chk("rst_ld_gray_c", 32'(gray_c), 0);
    rst_n = 1'b1; load = 1'b0;
    step();
    chk("first_bin", 32'(bin_a), 1);
    chk("first_gray", 32'(gray_a), 32'b0001);

    // full up-sweep from zero
    load = 1'b1; load_val = 8'h00; en = 1'b0;
    step();
    chk("sweep_start", 32'(bin_a), 0);
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("sweep_gray%0d", i), 32'(gray_a), 32'(gtab[i]));
      chk($sformatf("sweep_tc%0d", i), 32'(tc_a), (i == 15) ? 1 : 0);
    end

    // Gray load then count down through the wrap
    load = 1'b1; load_gray = 1'b1; load_val = 8'h0C; en = 1'b0;
    step();
    chk("gload_bin", 32'(bin_a), 8);
    chk("gload_gray", 32'(gray_a), 32'b1100);
    load = 1'b0; load_gray = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 8) begin
        chk("down_zero_bin", 32'(bin_a), 0);
        chk("down_zero_tc", 32'(tc_a), 0);
      end
    end
    chk("down_wrap_bin", 32'(bin_a), 15);
    chk("down_wrap_gray", 32'(gray_a), 32'b1000);
    chk("down_wrap_tc", 32'(tc_a), 1);

    // saturation on the WRAP=0 instance
    load = 1'b1; load_val = 8'h0E; en = 1'b0;
    step();
    chk("sat_load", 32'(bin_b), 14);
    load = 1'b0; en = 1'b1; up = 1'b1;
    step();
    chk("sat1_bin", 32'(bin_b), 15);
    chk("sat1_tc", 32'(tc_b), 0);
    step();
    chk("sat2_bin", 32'(bin_b), 15);
    chk("sat2_tc", 32'(tc_b), 1);
    chk("sat2_gray", 32'(gray_b), 32'b1000);
    step();
    chk("sat3_bin", 32'(bin_b), 15);
    chk("sat3_tc", 32'(tc_b), 1);
    chk("sat3_gray", 32'(gray_b), 32'b1000);
    up = 1'b0;
    step();
    chk("sat_down_bin", 32'(bin_b), 14);
    chk("sat_down_tc", 32'(tc_b), 0);

    // load beats enable
    load = 1'b1; load_val = 8'h05; en = 1'b0;
    step();
    chk("coll_pre", 32'(bin_a), 5);
    load_val = 8'h0A; en = 1'b1; up = 1'b1;
    step();
    chk("coll_bin", 32'(bin_a), 10);
    chk("coll_gray", 32'(gray_a), 32'b1111);
    chk("coll_tc", 32'(tc_a), 0);

    // 8-bit width: Gray 10000000 is binary 255, then wraps up to 0
    load = 1'b1; load_gray = 1'b1; load_val = 8'h80; en = 1'b0;
    step();
    chk("w8_load_bin", 32'(bin_c), 255);
    chk("w8_load_gray", 32'(gray_c), 32'h80);
    load = 1'b0; load_gray = 1'b0; en = 1'b1; up = 1'b1;
    step();
    chk("w8_wrap_bin", 32'(bin_c), 0);
    chk("w8_wrap_gray", 32'(gray_c), 0);
    chk("w8_wrap_tc", 32'(tc_c), 1);

    // random traffic, checked cycle by cycle against the model
    for (int i = 0; i < 1000; i++) begin
      rst_n     = ($urandom_range(0, 63) != 0);
      load      = ($urandom_range(0, 9) == 0);
      load_gray = 1'($urandom_range(0, 1));
      load_val  = 8'($urandom_range(0, 255));
      en        = ($urandom_range(0, 3) != 0);
      up        = 1'($urandom_range(0, 1));
      step();
    end

    rst_n = 1'b1; load = 1'b0; en = 1'b0;
    step();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
# gray_counter

Parametrised up/down counter that keeps a binary count and its reflected-binary Gray encoding in registers, so both are available glitch-free every cycle. It supports synchronous load of a start value given in either binary or Gray form, and a choice of wrap-around or saturating behaviour at the count limits. It is the sequential successor to the combinational binary-to-Gray converter. It is intended for pointer generation (e.g. async FIFO write/read pointers) and position/sequence counters elsewhere in the design.

## Interface

Parameters:
- len, 4: counter width in bits; legal range ≥ 2.
- WRAP, 1: 1 = count wraps modulo 2^len; 0 = count saturates at 0 and 2^len−1.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- EN  input  1  count enable; one step per cycle while high.
- UP  input  1  direction: 1 = increment, 0 = decrement; sampled only when EN=1.
- LOAD  input  1  synchronous load strobe.
- LOAD_GRAY  input  1  1 = LOAD_VAL is Gray-coded; 0 = LOAD_VAL is binary.
- LOAD_VAL  input  len  value to load.
- BIN  output  len  registered binary count.
- GRAY  output  len  registered Gray code of BIN.
- TC  output  1  registered terminal-count pulse.

## Operation

- State: binary count register b[len-1:0]. BIN = b. GRAY is a separate register loaded each cycle with gray(b_next).
- gray(x) = x ^ (x >> 1): MSB passes through; bit i = x[i+1] ^ x[i].
- Inverse, used for Gray loads: b[len-1] = g[len-1]; b[i] = b[i+1] ^ g[i], for i = len−2 down to 0.
- Per-cycle priority, highest first:
  1. RST_N=0: b=0, GRAY=0, TC=0.
  2. LOAD=1: b = LOAD_VAL, or the inverse-Gray of LOAD_VAL when LOAD_GRAY=1. TC=0. EN is ignored.
  3. EN=1, UP=1:
     - b < 2^len−1: b = b+1, TC=0.
     - b = 2^len−1, WRAP=1: b = 0, TC=1.
     - b = 2^len−1, WRAP=0: b holds, TC=1.
  4. EN=1, UP=0:
     - b > 0: b = b−1, TC=0.
     - b = 0, WRAP=1: b = 2^len−1, TC=1.
     - b = 0, WRAP=0: b holds, TC=1.
  5. Otherwise: b and GRAY hold, TC=0.
- Invariant: GRAY == gray(BIN) in every cycle, including the cycle after reset and the cycle after a load.
- Every counting step, including a wrap, changes exactly one GRAY bit. A saturated hold changes no bits.
- Arithmetic is modulo 2^len. No bit beyond len is kept or exposed.

## Timing

- Latency: 1 cycle. Inputs sampled at edge k appear on BIN/GRAY/TC after edge k.
- Reset values: BIN=0, GRAY=0, TC=0. Reset is applied on the first edge with RST_N low.
- Reset during counting, or coinciding with LOAD or EN, overrides everything. The next values are all zero.
- TC is high for exactly one cycle per limit event.
  - EN held high through repeated saturated steps gives TC=1 on every such cycle.
  - In wrap mode, TC is high in the cycle BIN shows the wrapped value (0 when counting up, 2^len−1 when counting down).
- LOAD and EN both high: the load wins. No step is taken and TC=0.
- A direction change (UP toggling) takes effect on the next enabled edge. There is no dead cycle.
- No combinational path from any input to any output.

## Test plan

All scenarios use len=4 unless stated.
- **Reset:** assert RST_N=0 with EN=1, UP=1 for 2 cycles, then release → BIN=0, GRAY=0000, TC=0 while in reset. First enabled edge after release gives BIN=1, GRAY=0001.
- **Full up-sweep, WRAP=1:** from 0, EN=1, UP=1 for 16 cycles → GRAY follows 0000, 0001, 0011, 0010, 0110, … , 1000, then 0000. Exactly one bit changes per step. TC=1 only on the 15→0 cycle.
- **Gray load then count down, WRAP=1:** LOAD=1, LOAD_GRAY=1, LOAD_VAL=1100 → BIN=1000, GRAY=1100. Then EN=1, UP=0 for 9 cycles → BIN reaches 0 after 8 steps, then 15 (GRAY=1000) with TC=1.
- **Saturation, WRAP=0:** load binary 1110. EN=1, UP=1 for 3 cycles → BIN=15, TC=0; then BIN=15, TC=1; then BIN=15, TC=1. GRAY stays 1000. Then UP=0 → BIN=14, TC=0.
- **Load versus enable collision:** BIN=5 with LOAD=1, LOAD_GRAY=0, LOAD_VAL=1010, EN=1 → BIN=10, GRAY=1111, TC=0.
- **Width scaling:** len=8, WRAP=1, load gray 10000000 (binary 255), EN=1, UP=1 → BIN=0, GRAY=0, TC=1. Check the GRAY==gray(BIN) invariant on 1000 random EN/UP/LOAD cycles.
